// File: rtl/output_arbiter.sv
// -----------------------------------------------------------------------------
// output_arbiter
//
// Wormhole arbiter for one NoC router output port. Up to NUM_IN input
// buffers compete for the port. Selection is round-robin. The winner keeps the
// port from its head flit through its tail flit. A flit is popped only while
// the downstream FIFO is not full. The popped flit is registered and then
// written downstream.
//
// Optional feature: define OUTPUT_ARBITER_TIMEOUT_EN to add a lock watchdog.
// The watchdog releases a port that has stalled for TIMEOUT_CYC cycles and
// sets a sticky err flag. Without the macro, err is tied low and the lock is
// held indefinitely.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   req       [NUM_IN]         input i holds a flit
//   tail      [NUM_IN]         flit presented by input i is a tail flit
//   flit_in   [NUM_IN*DATA_W]  flattened flits, input i at [i*DATA_W +: DATA_W]
//   full      downstream FIFO full (one-flit slack already included)
//   grant     [NUM_IN]         one-hot pop to input i (combinational)
//   flit_out  [DATA_W]         registered flit to downstream
//   write     registered write strobe to downstream
//   busy      port locked to an owner
//   owner     [3]              index of current or last owner
//   err       watchdog fired (sticky)
//
// State table:
//   IDLE   | no owner; round-robin arbitration among requesters
//   LOCKED | port owned; owner's flits pass while downstream not full
// -----------------------------------------------------------------------------
module output_arbiter #(
  parameter int NUM_IN      = 5,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        req,
  input  logic [NUM_IN-1:0]        tail,
  input  logic [NUM_IN*DATA_W-1:0] flit_in,
  input  logic                     full,
  output logic [NUM_IN-1:0]        grant,
  output logic [DATA_W-1:0]        flit_out,
  output logic                     write,
  output logic                     busy,
  output logic [2:0]               owner,
  output logic                     err
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [2:0]        rr_ptr;
  logic [2:0]        pick;
  logic              found;
  logic [3:0]        scan_idx;
  logic [2:0]        owner_inc;
  logic              xfer;
  logic              timeout;
  logic [7:0]        req_pad;
  logic [7:0]        tail_pad;
  logic [DATA_W-1:0] flit_arr [8];

  if (NUM_IN < 2 || NUM_IN > 8) begin : g_chk_num_in
    $error("output_arbiter: NUM_IN must be in 2..8");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_chk_timeout
    $error("output_arbiter: TIMEOUT_CYC must be in 1..255");
  end

  // Pad the per-input vectors to eight entries so that a 3-bit owner or scan
  // index can address them for any NUM_IN.
  assign req_pad  = 8'(req);
  assign tail_pad = 8'(tail);

  for (genvar i = 0; i < 8; i++) begin : g_flit
    if (i < NUM_IN) begin : g_used
      assign flit_arr[i] = flit_in[i*DATA_W +: DATA_W];
    end else begin : g_pad
      assign flit_arr[i] = '0;
    end
  end

  // Round-robin pick: the first requester at or after rr_ptr, with wrap.
  always_comb begin
    pick     = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      scan_idx = 4'(rr_ptr) + 4'(k);
      if (scan_idx >= 4'(NUM_IN)) begin
        scan_idx = scan_idx - 4'(NUM_IN);
      end
      if (!found && req_pad[scan_idx[2:0]]) begin
        found = 1'b1;
        pick  = scan_idx[2:0];
      end
    end
  end

  assign owner_inc = (owner == 3'(NUM_IN - 1)) ? 3'd0 : owner + 3'd1;

  always_comb begin
    state_nxt = state;
    grant     = '0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (req_pad[owner] && !full) begin
          xfer  = 1'b1;
          grant = NUM_IN'(8'd1 << owner);
          if (tail_pad[owner]) begin
            state_nxt = IDLE;
          end
        end
        if (timeout) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      owner    <= '0;
      flit_out <= '0;
      write    <= 1'b0;
    end else begin
      write <= xfer;
      if (xfer) begin
        flit_out <= flit_arr[owner];
      end
      if (state == IDLE && found) begin
        owner <= pick;
      end
      // Releasing the lock, by tail or by watchdog, moves priority past the owner.
      if ((xfer && tail_pad[owner]) || timeout) begin
        rr_ptr <= owner_inc;
      end
    end
  end

  assign busy = (state == LOCKED);

`ifdef OUTPUT_ARBITER_TIMEOUT_EN
  logic [7:0] stall_cnt;

  // The counter sits at zero outside LOCKED, so it starts from zero on each
  // lock. It fires on the stalled cycle that would bring it to TIMEOUT_CYC.
  assign timeout = (state == LOCKED) && !xfer &&
                   ((stall_cnt + 8'd1) == 8'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (state != LOCKED || xfer || timeout) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + 8'd1;
      end
      if (timeout) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_output_arbiter.sv
module tb_output_arbiter;
  localparam int N = 5;
  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   tail;
  logic [N*W-1:0] flit_in;
  logic           full;
  logic [N-1:0]   grant;
  logic [W-1:0]   flit_out;
  logic           write;
  logic           busy;
  logic [2:0]     owner;
  logic           err;

  output_arbiter #(.NUM_IN(N), .DATA_W(W), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .flit_in(flit_in),
    .full(full), .grant(grant), .flit_out(flit_out), .write(write),
    .busy(busy), .owner(owner), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W:0]   up_q [N][$];
  logic [W-1:0] exp_q [$];
  logic [N-1:0] en;
  logic [N-1:0] g_smp;
  logic         prev_xfer;
  int           tests = 0;
  int           fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input int i, input int n);
    return W'(32'hA000_0000 + i * 256 + n);
  endfunction

  // Queue a packet of n flits on input i; the last flit carries tail.
  task automatic load(input int i, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      up_q[i].push_back({(k == n - 1), mk(i, base + k)});
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (en[i] && up_q[i].size() > 0) begin
        req[i]          = 1'b1;
        tail[i]         = up_q[i][0][W];
        flit_in[i*W +: W] = up_q[i][0][W-1:0];
      end else begin
        req[i]          = 1'b0;
        tail[i]         = 1'b0;
        flit_in[i*W +: W] = '0;
      end
    end
  endtask

  // One cycle: apply inputs, check grant/busy, cross the edge, then pop any
  // upstream flit that was granted before that edge.
  task automatic step(input logic f, input logic [N-1:0] e,
                      input logic [N-1:0] eg, input logic eb);
    full = f;
    en   = e;
    drive();
    #1;
    chk("grant", 32'(grant), 32'(eg));
    chk("busy", 32'(busy), 32'(eb));
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (g_smp[i] && up_q[i].size() > 0) void'(up_q[i].pop_front());
    end
  endtask

  task automatic flush_upstream();
    for (int i = 0; i < N; i++) up_q[i].delete();
    g_smp     = '0;
    prev_xfer = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_upstream();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin
    g_smp     = '0;
    prev_xfer = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        g_smp     = '0;
        prev_xfer = 1'b0;
      end else begin
        if (grant != '0) begin
          chk("grant_onehot", 32'($onehot(grant)), 32'd1);
          chk("grant_owner", 32'(grant), 32'd1 << owner);
        end
        chk("write_latency", 32'(write), 32'(prev_xfer));
        if (write) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got %h expected no write", flit_out);
          end else begin
            chk("flit_out", flit_out, exp_q.pop_front());
          end
        end
        g_smp     = grant;
        prev_xfer = |grant;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb_output_arbiter timeout");
  end

  localparam logic [N-1:0] ALL = '1;
  logic [N-1:0] t2_g [13];

  initial begin
    rst = 1'b1;
    full = 1'b0;
    en = '0;
    req = '0;
    tail = '0;
    flit_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_flit_out", flit_out, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Three-flit packet on input 2
    load(2, 3, 0);
    exp_q.push_back(mk(2, 0)); exp_q.push_back(mk(2, 1)); exp_q.push_back(mk(2, 2));
    step(0, ALL, 5'b00000, 0);
    step(0, ALL, 5'b00100, 1);
    step(0, ALL, 5'b00100, 1);
    step(0, ALL, 5'b00100, 1);
    step(0, ALL, 5'b00000, 0);
    chk("t1_last_owner", 32'(owner), 32'd2);

    // All five requesting single-flit packets; rr starts at 0 after reset
    do_reset();
    for (int i = 0; i < N; i++) load(i, 1, 16);
    load(0, 1, 32);
    exp_q.push_back(mk(0, 16)); exp_q.push_back(mk(1, 16)); exp_q.push_back(mk(2, 16));
    exp_q.push_back(mk(3, 16)); exp_q.push_back(mk(4, 16)); exp_q.push_back(mk(0, 32));
    t2_g = '{5'b00000, 5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b00100, 5'b00000,
             5'b01000, 5'b00000, 5'b10000, 5'b00000, 5'b00001, 5'b00000};
    for (int k = 0; k < 13; k++) step(0, ALL, t2_g[k], (t2_g[k] != '0));

    // Owner 1 stalled by full for 4 cycles while input 3 waits (rr = 1)
    load(1, 4, 48);
    load(3, 1, 48);
    exp_q.push_back(mk(1, 48)); exp_q.push_back(mk(1, 49));
    exp_q.push_back(mk(1, 50)); exp_q.push_back(mk(1, 51)); exp_q.push_back(mk(3, 48));
    step(0, ALL, 5'b00000, 0);
    step(0, ALL, 5'b00010, 1);
    step(0, ALL, 5'b00010, 1);
    repeat (4) step(1, ALL, 5'b00000, 1);
    chk("t3_owner_hold", 32'(owner), 32'd1);
    step(0, ALL, 5'b00010, 1);
    step(0, ALL, 5'b00010, 1);
    step(0, ALL, 5'b00000, 0);
    step(0, ALL, 5'b01000, 1);
    step(0, ALL, 5'b00000, 0);

    // Owner 0 loses req for 3 cycles (rr = 4 wraps to 0)
    load(0, 3, 64);
    exp_q.push_back(mk(0, 64)); exp_q.push_back(mk(0, 65)); exp_q.push_back(mk(0, 66));
    step(0, ALL, 5'b00000, 0);
    step(0, ALL, 5'b00001, 1);
    repeat (3) step(0, 5'b11110, 5'b00000, 1);
    chk("t4_owner_hold", 32'(owner), 32'd0);
    step(0, ALL, 5'b00001, 1);
    step(0, ALL, 5'b00001, 1);
    step(0, ALL, 5'b00000, 0);

    // Reset in the middle of a packet on input 4
    load(4, 4, 80);
    exp_q.push_back(mk(4, 80)); exp_q.push_back(mk(4, 81));
    step(0, ALL, 5'b00000, 0);
    step(0, ALL, 5'b10000, 1);
    step(0, ALL, 5'b10000, 1);
    drive();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_write", 32'(write), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_owner", 32'(owner), 32'd0);
    chk("mid_rst_flit_out", flit_out, 32'd0);
    flush_upstream();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    load(0, 1, 96);
    load(4, 1, 96);
    exp_q.push_back(mk(0, 96)); exp_q.push_back(mk(4, 96));
    step(0, ALL, 5'b00000, 0);
    chk("t5_owner", 32'(owner), 32'd0);
    step(0, ALL, 5'b00001, 1);
    step(0, ALL, 5'b00000, 0);
    step(0, ALL, 5'b10000, 1);
    step(0, ALL, 5'b00000, 0);

`ifdef OUTPUT_ARBITER_TIMEOUT_EN
    // Owner 2 stalls 8 cycles: watchdog releases, input 3 wins next (rr = 0)
    load(2, 2, 112);
    load(3, 1, 112);
    exp_q.push_back(mk(2, 112)); exp_q.push_back(mk(3, 112)); exp_q.push_back(mk(2, 113));
    step(0, ALL, 5'b00000, 0);
    step(0, ALL, 5'b00100, 1);
    repeat (7) step(1, ALL, 5'b00000, 1);
    chk("wd_err_before", 32'(err), 32'd0);
    step(1, ALL, 5'b00000, 1);
    chk("wd_err_set", 32'(err), 32'd1);
    step(1, ALL, 5'b00000, 0);
    chk("wd_next_owner", 32'(owner), 32'd3);
    step(0, ALL, 5'b01000, 1);
    step(0, ALL, 5'b00000, 0);
    step(0, ALL, 5'b00100, 1);
    step(0, ALL, 5'b00000, 0);
    chk("wd_err_sticky", 32'(err), 32'd1);
`else
    // Without the watchdog, a long stall keeps the lock indefinitely
    load(2, 2, 112);
    exp_q.push_back(mk(2, 112)); exp_q.push_back(mk(2, 113));
    step(0, ALL, 5'b00000, 0);
    step(0, ALL, 5'b00100, 1);
    repeat (10) step(1, ALL, 5'b00000, 1);
    chk("stall_owner", 32'(owner), 32'd2);
    step(0, ALL, 5'b00100, 1);
    step(0, ALL, 5'b00000, 0);
    chk("err_tied_low", 32'(err), 32'd0);
`endif

    step(0, ALL, 5'b00000, 0);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < N; i++) chk("upstream_empty", 32'(up_q[i].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/output_arbiter.md
Name: output_arbiter

Overview:
- Per-output-port wormhole arbiter for the NoC router.
- Shares one output port among NUM_IN input buffers (default N/E/S/W/Local) with round-robin selection.
- Locks the port to the winner from head flit to tail flit.
- Pops flits only when the downstream FIFO is not full, and drives the registered flit/write pair into the downstream buffer.

Parameters:
- NUM_IN, 5: number of requesting input ports (2..8).
- DATA_W, 32: flit width in bits.
- TIMEOUT_CYC, 255: stall limit in cycles for the lock watchdog (used only with the optional feature); 8-bit counter, valid range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- req  input  NUM_IN  input i holds a flit (its FIFO is not empty)
- tail  input  NUM_IN  flit currently presented by input i is a tail flit
- flit_in  input  NUM_IN*DATA_W  flattened flits; input i occupies bits [i*DATA_W +: DATA_W]
- full  input  1  downstream FIFO full (must already include one-flit slack)
- grant  output  NUM_IN  one-hot pop to input FIFO i, combinational
- flit_out  output  DATA_W  registered flit to downstream
- write  output  1  registered write strobe to downstream
- busy  output  1  port locked to an owner
- owner  output  3  index of current or last owner
- err  output  1  watchdog fired (sticky); constant 0 without the optional feature

Behaviour:
- Reset values: state IDLE, rr pointer 0, owner 0, grant 0, write 0, flit_out 0, busy 0, err 0.
- FSM has two states, IDLE and LOCKED.
- IDLE:
  - If req is nonzero, pick the first set bit scanning from the rr pointer upward, wrapping at NUM_IN-1 to 0.
  - Register it as owner; go to LOCKED next cycle.
  - No flit moves in the arbitration cycle, so minimum head latency is 1 cycle of arbitration, 1 cycle of transfer, then write visible the cycle after.
  - If req is 0, stay in IDLE.
- LOCKED:
  - busy=1.
  - Transfer condition: req[owner] && !full.
  - On transfer: grant[owner]=1 in the same cycle (combinational); next edge flit_out<=flit_in[owner] and write<=1.
  - Otherwise grant=0 and write<=0 at the next edge. flit_out holds its last value.
- Tail handling:
  - A transfer with tail[owner]=1 releases the lock: next state IDLE, rr pointer <= owner+1 (wraps to 0 past NUM_IN-1).
  - Re-arbitration happens in the following IDLE cycle. Any requester, including the same input, may win per the rr order.
- Requests from non-owners are ignored while LOCKED. grant is never multi-hot, and is never set outside LOCKED.
- full toggling mid-packet: stall, no drop or duplicate; resume on the first cycle with !full.
- Owner dropping req mid-packet (its FIFO went empty): hold the lock and wait.
- Single-flit packet (head=tail): one transfer, then release.
- Back-to-back packets from the same input: an IDLE cycle is always inserted between them.
- Reset mid-packet: immediate return to the reset values. The upstream is responsible for its own flush.
- flit_in for an input whose req=0 is don't-care.

Optional Feature:
- Macro: OUTPUT_ARBITER_TIMEOUT_EN.
- Defined:
  - An 8-bit stall counter clears on entering LOCKED and on every transfer, and increments in each LOCKED cycle with no transfer.
  - When it reaches TIMEOUT_CYC, force IDLE, advance the rr pointer past owner, and set err=1.
  - err stays set until rst.
- Undefined: no counter logic; err tied to 0; the lock is held indefinitely.

Test Plan:
- Reset, then req=5'b00100, tail on the 3rd flit, full=0 -> grant[2] pulses 3 consecutive cycles starting 1 cycle after req; write high 3 cycles one cycle later; flit_out matches the sequence; busy drops after the tail.
- req=5'b11111 held, all packets single-flit -> owners serviced in order 0,1,2,3,4,0; each grant one-hot; one idle arbitration cycle between packets.
- Owner 1 mid-packet, full asserted 4 cycles -> grant=0 and write=0 for those cycles; no flit lost or duplicated; req[3] ignored until owner 1's tail.
- Owner 0 sending, req[0] drops for 3 cycles -> lock held, busy=1, grant=0; resumes with the next flit when req[0] returns.
- rst asserted mid-packet on owner 4 -> write, grant, busy, owner all 0 asynchronously; after release, req=5'b10001 wins input 0.
- With OUTPUT_ARBITER_TIMEOUT_EN and TIMEOUT_CYC=8: owner stalls with full=1 -> after 8 stalled cycles the lock is released, err=1 (sticky), and the next requester is granted.
